// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read-channel arbiter: one burst in flight, R beats routed by registered grant.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 1 wins).
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 (icache)
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [31:0]           m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // master 1 (dcache)
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [31:0]           m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  // slave side
  output logic [ID_WIDTH-1:0]   s_arid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  output logic [1:0]            s_arlock,
  output logic [3:0]            s_arcache,
  output logic [2:0]            s_arprot,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [31:0]           s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state_reg, state_next;
  logic                    grant_reg;
  logic [ID_WIDTH-1:0]     arid_reg;
  logic [ADDR_WIDTH-1:0]   araddr_reg;
  logic [7:0]              arlen_reg;
  logic [2:0]              arsize_reg;
  logic [1:0]              arburst_reg;
  logic                    req_any;
  logic                    win;
  logic                    grant_fire;
  logic                    unused_rid;

  // Routing relies solely on grant_reg; the slave's ID is not needed.
  assign unused_rid = ^s_rid;

  assign req_any    = m0_arvalid | m1_arvalid;
  assign grant_fire = (state_reg == IDLE) && req_any;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr_reg;

  always_comb begin
    win = m1_arvalid;
    if (m0_arvalid && m1_arvalid) win = rr_ptr_reg;
  end

  // Preferred port flips to whoever lost the latest grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rr_ptr_reg <= 1'b0;
    else if (grant_fire) rr_ptr_reg <= ~win;
  end
`else
  assign win = m1_arvalid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b0;
      arid_reg    <= '0;
      araddr_reg  <= '0;
      arlen_reg   <= '0;
      arsize_reg  <= '0;
      arburst_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_fire) begin
        grant_reg   <= win;
        arid_reg    <= {{(ID_WIDTH-1){1'b0}}, win};
        araddr_reg  <= win ? m1_araddr  : m0_araddr;
        arlen_reg   <= win ? m1_arlen   : m0_arlen;
        arsize_reg  <= win ? m1_arsize  : m0_arsize;
        arburst_reg <= win ? m1_arburst : m0_arburst;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (req_any) state_next = ADDR;
      ADDR:    if (s_arready) state_next = DATA;
      DATA:    if (s_rvalid && s_rready && s_rlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    s_rready   = 1'b0;
    // Ack is combinational, so it must also be squashed while reset is asserted.
    if (grant_fire && !rst) begin
      m0_arready = ~win;
      m1_arready = win;
    end
    if (state_reg == DATA) begin
      if (grant_reg) begin
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        s_rready  = m1_rready;
      end else begin
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        s_rready  = m0_rready;
      end
    end
  end

  assign s_arvalid = (state_reg == ADDR);
  assign s_arid    = arid_reg;
  assign s_araddr  = araddr_reg;
  assign s_arlen   = arlen_reg;
  assign s_arsize  = arsize_reg;
  assign s_arburst = arburst_reg;
  assign s_arlock  = 2'b00;
  assign s_arcache = 4'b0000;
  assign s_arprot  = 3'b000;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed testbench for axi_read_arbiter; acts as both cache masters and the AXI slave.
// Expectations follow the ARB_ROUND_ROBIN_EN build setting.
module tb_axi_read_arbiter;
  localparam int AW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] m0_araddr, m1_araddr;
  logic [7:0]    m0_arlen, m1_arlen;
  logic [2:0]    m0_arsize, m1_arsize;
  logic [1:0]    m0_arburst, m1_arburst;
  logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [1:0]    m0_rresp, m1_rresp;
  logic          m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [IW-1:0] s_arid, s_rid;
  logic [AW-1:0] s_araddr;
  logic [7:0]    s_arlen;
  logic [2:0]    s_arsize;
  logic [1:0]    s_arburst, s_arlock;
  logic [3:0]    s_arcache;
  logic [2:0]    s_arprot;
  logic          s_arvalid, s_arready;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast, s_rvalid, s_rready;

  int n_cmp = 0;
  int n_bad = 0;

  axi_read_arbiter #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  // Entered in a drive phase (just after a posedge) with the requesting arvalid(s) set.
  // Plays the slave for one burst and checks grant, AR payload and every routed beat.
  // abort_at >= 0 returns at the sample point while beat index abort_at is presented.
  task automatic serve_burst(input int p, input logic [31:0] addr, input int len,
                             input int ar_delay, input bit toggle, input bit keep,
                             input int abort_at);
    logic [31:0] exp_data, md, od;
    logic [1:0]  mresp;
    logic        arr_p, arr_o, mv, ov, mr, ml;
    bit          hs;
    int          i, beats, guard;
    @(negedge clk);
    arr_p = p ? m1_arready : m0_arready;
    arr_o = p ? m0_arready : m1_arready;
    n_cmp++; if (arr_p !== 1'b1) begin n_bad++; $display("FAIL grant_ack port=%0d got=%b exp=1", p, arr_p); end
    n_cmp++; if (arr_o !== 1'b0) begin n_bad++; $display("FAIL loser_ack port=%0d got=%b exp=0", 1-p, arr_o); end
    n_cmp++; if ({s_arvalid, s_rready, m0_rvalid, m1_rvalid} !== 4'b0000) begin
      n_bad++; $display("FAIL idle_quiet got=%b exp=0000", {s_arvalid, s_rready, m0_rvalid, m1_rvalid}); end
    @(posedge clk); #1;
    if (!keep) begin if (p == 1) m1_arvalid = 1'b0; else m0_arvalid = 1'b0; end
    s_arready = (ar_delay == 0);
    @(negedge clk);
    n_cmp++; if (s_arid !== IW'(p)) begin n_bad++; $display("FAIL arid got=%0d exp=%0d", s_arid, p); end
    n_cmp++; if (s_araddr !== addr) begin n_bad++; $display("FAIL araddr got=%h exp=%h", s_araddr, addr); end
    n_cmp++; if (s_arlen !== 8'(len)) begin n_bad++; $display("FAIL arlen got=%0d exp=%0d", s_arlen, len); end
    n_cmp++; if (s_arsize !== 3'(p == 1 ? 3 : 2)) begin n_bad++; $display("FAIL arsize got=%0d exp=%0d", s_arsize, p == 1 ? 3 : 2); end
    for (int c = 0; c <= ar_delay; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++; if ({s_arvalid, m0_arready, m1_arready} !== 3'b100) begin
        n_bad++; $display("FAIL ar_hold cycle=%0d got=%b exp=100", c, {s_arvalid, m0_arready, m1_arready}); end
      @(posedge clk); #1;
      s_arready = (c + 1 == ar_delay);
    end
    s_arready = 1'b0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    i = 0;
    beats = 0;
    exp_data = 32'hD000_0000 + 32'(p) * 32'h0001_0000;
    s_rvalid = 1'b1; s_rdata = exp_data; s_rresp = 2'b00; s_rlast = (len == 0);
    for (guard = 0; guard < 300; guard++) begin
      @(negedge clk);
      mv = p ? m1_rvalid : m0_rvalid;  ov = p ? m0_rvalid : m1_rvalid;
      md = p ? m1_rdata  : m0_rdata;   od = p ? m0_rdata  : m1_rdata;
      mresp = p ? m1_rresp : m0_rresp; ml = p ? m1_rlast : m0_rlast;
      mr = p ? m1_rready : m0_rready;
      n_cmp++; if ({mv, ov} !== 2'b10) begin n_bad++; $display("FAIL rvalid_route beat=%0d got=%b exp=10", i, {mv, ov}); end
      n_cmp++; if (md !== exp_data || od !== 32'h0) begin
        n_bad++; $display("FAIL rdata beat=%0d got=%h/%h exp=%h/00000000", i, md, od, exp_data); end
      n_cmp++; if (mresp !== 2'(i) || ml !== (i == len)) begin
        n_bad++; $display("FAIL rresp_rlast beat=%0d got=%0d/%b exp=%0d/%b", i, mresp, ml, i % 4, i == len); end
      n_cmp++; if (s_rready !== mr || m0_arready !== 1'b0 || m1_arready !== 1'b0) begin
        n_bad++; $display("FAIL rready_noack beat=%0d got=%b%b%b exp=%b00", i, s_rready, m0_arready, m1_arready, mr); end
      if (abort_at >= 0 && i == abort_at) begin
        $display("burst port=%0d addr=%h aborted at beat %0d", p, addr, i + 1);
        return;
      end
      hs = mr;
      if (hs) beats++;
      @(posedge clk); #1;
      if (hs) begin
        i++;
        if (i > len) break;
        exp_data = exp_data + 32'd1;
        s_rdata = exp_data; s_rresp = 2'(i); s_rlast = (i == len);
      end
      if (toggle) begin if (p == 1) m1_rready = ~m1_rready; else m0_rready = ~m0_rready; end
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = '0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    n_cmp++; if (beats != len + 1) begin n_bad++; $display("FAIL beat_count port=%0d got=%0d exp=%0d", p, beats, len + 1); end
    $display("burst port=%0d addr=%h len=%0d beats=%0d", p, addr, len, beats);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_arvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({m0_arready, m1_arready, s_arvalid, s_rready, m0_rvalid, m1_rvalid} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctl got=%b exp=000000", {m0_arready, m1_arready, s_arvalid, s_rready, m0_rvalid, m1_rvalid}); end
    n_cmp++; if ({s_arid, s_araddr, s_arlen, s_arsize, s_arburst} !== '0) begin
      n_bad++; $display("FAIL reset_payload got=%h/%h/%h exp=0", s_arid, s_araddr, s_arlen); end
    n_cmp++; if ({s_arlock, s_arcache, s_arprot} !== 9'b0) begin
      n_bad++; $display("FAIL ar_consts got=%b exp=0", {s_arlock, s_arcache, s_arprot}); end
    m0_arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_simultaneous();
    m0_araddr = 32'h0000_1000; m0_arlen = 8'd3;
    m1_araddr = 32'h8000_2000; m1_arlen = 8'd1;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    serve_burst(0, 32'h0000_1000, 3, 0, 1'b0, 1'b0, -1);
    serve_burst(1, 32'h8000_2000, 1, 0, 1'b0, 1'b0, -1);
`else
    serve_burst(1, 32'h8000_2000, 1, 0, 1'b0, 1'b0, -1);
    serve_burst(0, 32'h0000_1000, 3, 0, 1'b0, 1'b0, -1);
`endif
  endtask

  task automatic test_continuous();
    int seq [4];
`ifdef ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{1, 1, 1, 1};
`endif
    @(posedge clk); #1;
    m0_araddr = 32'h0000_3000; m0_arlen = 8'd2;
    m1_araddr = 32'h8000_4000; m1_arlen = 8'd2;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    for (int k = 0; k < 4; k++)
      serve_burst(seq[k], seq[k] == 1 ? 32'h8000_4000 : 32'h0000_3000, 2, 0, 1'b0, 1'b1, -1);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    m0_araddr = 32'h1FC0_0000; m0_arlen = 8'd15; m0_arvalid = 1'b1;
    serve_burst(0, 32'h1FC0_0000, 15, 0, 1'b0, 1'b0, -1);
    @(negedge clk);
    n_cmp++; if ({s_arvalid, s_rready, m0_rvalid, m0_arready} !== 4'b0) begin
      n_bad++; $display("FAIL idle_after got=%b exp=0000", {s_arvalid, s_rready, m0_rvalid, m0_arready}); end
  endtask

  task automatic test_stall();
    @(posedge clk); #1;
    m1_araddr = 32'h4000_0040; m1_arlen = 8'd7; m1_arvalid = 1'b1;
    serve_burst(1, 32'h4000_0040, 7, 3, 1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    m0_araddr = 32'h0000_5000; m0_arlen = 8'd7; m0_arvalid = 1'b1;
    serve_burst(0, 32'h0000_5000, 7, 0, 1'b0, 1'b0, 4);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({m0_rvalid, m1_rvalid, s_rready, s_arvalid, m0_arready, m1_arready} !== 6'b0) begin
      n_bad++; $display("FAIL async_reset_ctl got=%b exp=000000", {m0_rvalid, m1_rvalid, s_rready, s_arvalid, m0_arready, m1_arready}); end
    n_cmp++; if (m0_rdata !== 32'h0 || s_araddr !== 32'h0) begin
      n_bad++; $display("FAIL async_reset_data got=%h/%h exp=0/0", m0_rdata, s_araddr); end
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    m0_araddr = 32'h0000_6000; m0_arlen = 8'd1; m0_arvalid = 1'b1;
    serve_burst(0, 32'h0000_6000, 1, 0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    rst = 1'b1;
    m0_araddr = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1; m0_arvalid = 1'b0; m0_rready = 1'b1;
    m1_araddr = '0; m1_arlen = '0; m1_arsize = 3'd3; m1_arburst = 2'd2; m1_arvalid = 1'b0; m1_rready = 1'b1;
    s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    test_reset();
    test_simultaneous();
    test_continuous();
    test_single();
    test_stall();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
